// File: rtl/kvt_scfifo_wr_arbiter.sv
// Write-side arbiter for a single-clock FIFO: round-robin grants with bounded bursts,
// a registered write port and a locally tracked occupancy count.
`ifndef DW
`define DW 8
`endif
`ifndef AW
`define AW 4
`endif

module kvt_scfifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DW        = `DW,
    parameter int AW        = `AW,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*DW-1:0]      req_data_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       wr_en_o,
    output logic [DW-1:0]              wr_data_o,
    input  logic                       fifo_rd_en_i,
    input  logic                       fifo_empty_i,
    input  logic                       fifo_full_i,
    output logic [AW:0]                level_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
    output logic                       overflow_err_o
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int BW  = $clog2(MAX_BURST + 1);
    localparam int LW  = AW + 1;
    localparam logic [LW-1:0] DEPTH = LW'(1) << AW;

    if (DW < 1) begin : g_bad_dw
        $error("kvt_scfifo_wr_arbiter: DW must be >= 1");
    end
    if (AW < 1) begin : g_bad_aw
        $error("kvt_scfifo_wr_arbiter: AW must be >= 1");
    end
    if (MAX_BURST < 1) begin : g_bad_burst
        $error("kvt_scfifo_wr_arbiter: MAX_BURST must be >= 1");
    end
    if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
        $error("kvt_scfifo_wr_arbiter: NUM_REQ must be in 2..16");
    end

    typedef enum logic {
        ARB,
        LOCK
    } state_t;

    state_t             state, state_nxt;
    logic [IDW-1:0]     owner, owner_nxt;
    logic [IDW-1:0]     rr_ptr, rr_nxt;
    logic [BW-1:0]      beat_cnt, cnt_nxt;
    logic [LW-1:0]      level;
    logic [IDW-1:0]     found_idx, acc_id;
    logic               found, accept, can_issue, rd_ok;
    logic [NUM_REQ-1:0] ready_c;
    logic [DW-1:0]      data_arr [NUM_REQ];
    int                 cand;

    function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
        return (id == IDW'(NUM_REQ - 1)) ? '0 : id + 1'b1;
    endfunction

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data_i[g*DW +: DW];
    end

    assign can_issue = (level < DEPTH);
    assign rd_ok     = fifo_rd_en_i && !fifo_empty_i;

    // Rotating priority search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        found_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!found && req_valid_i[IDW'(cand)]) begin
                found     = 1'b1;
                found_idx = IDW'(cand);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        rr_nxt    = rr_ptr;
        cnt_nxt   = beat_cnt;
        ready_c   = '0;
        accept    = 1'b0;
        acc_id    = '0;
        case (state)
            ARB: begin
                if (can_issue && found) begin
                    ready_c[found_idx] = 1'b1;
                    accept             = 1'b1;
                    acc_id             = found_idx;
                    if (MAX_BURST == 1) begin
                        rr_nxt = next_id(found_idx);
                    end else begin
                        state_nxt = LOCK;
                        owner_nxt = found_idx;
                        cnt_nxt   = BW'(1);
                    end
                end
            end
            LOCK: begin
                // A full FIFO freezes the burst exactly where it is.
                if (can_issue) begin
                    if (req_valid_i[owner]) begin
                        ready_c[owner] = 1'b1;
                        accept         = 1'b1;
                        acc_id         = owner;
                        if (beat_cnt + BW'(1) == BW'(MAX_BURST)) begin
                            state_nxt = ARB;
                            rr_nxt    = next_id(owner);
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = beat_cnt + BW'(1);
                        end
                    end else begin
                        state_nxt = ARB;
                        rr_nxt    = next_id(owner);
                        cnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end

    // Ready is combinational, so it is masked directly while reset is held.
    assign req_ready_o = rst ? ready_c : '0;
    assign level_o     = level;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ARB;
            owner    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            beat_cnt <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_o    <= 1'b0;
            wr_data_o  <= '0;
            grant_id_o <= '0;
        end else begin
            wr_en_o <= accept;
            if (accept) begin
                wr_data_o  <= data_arr[acc_id];
                grant_id_o <= acc_id;
            end
        end
    end

    // Occupancy counts a beat at acceptance; acceptance already requires room.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level <= '0;
        end else if (accept && !rd_ok) begin
            level <= level + 1'b1;
        end else if (!accept && rd_ok && level != '0) begin
            level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_err_o <= 1'b0;
        end else if (wr_en_o && fifo_full_i && !fifo_rd_en_i) begin
            overflow_err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_kvt_scfifo_wr_arbiter.sv
// Directed bench for kvt_scfifo_wr_arbiter: a vector table for round-robin bursts
// and lock behaviour, plus hand sequences for fill, drain, overflow and reset.
module tb_kvt_scfifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DW        = 8;
    localparam int AW        = 2;
    localparam int MAX_BURST = 4;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*DW-1:0]   req_data;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    wr_en;
    logic [DW-1:0]           wr_data;
    logic                    fifo_rd_en;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [AW:0]             level;
    logic [1:0]              grant_id;
    logic                    overflow_err;

    int checks = 0;
    int errors = 0;
    int acc_count;

    logic [7:0] req_bytes [4];

    typedef struct {
        logic [3:0] valid;
        logic       rd_en;
        logic       empty;
        logic [3:0] exp_ready;
        logic       exp_wr_en;
        logic [7:0] exp_data;
        logic [2:0] exp_level;
        logic [1:0] exp_grant;
    } vec_t;

    vec_t vecs [20];

    always #5 clk = ~clk;

    kvt_scfifo_wr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DW       (DW),
        .AW       (AW),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .wr_en_o       (wr_en),
        .wr_data_o     (wr_data),
        .fifo_rd_en_i  (fifo_rd_en),
        .fifo_empty_i  (fifo_empty),
        .fifo_full_i   (fifo_full),
        .level_o       (level),
        .grant_id_o    (grant_id),
        .overflow_err_o(overflow_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic rd_en, input logic empty, input logic full);
        req_valid  = valid;
        fifo_rd_en = rd_en;
        fifo_empty = empty;
        fifo_full  = full;
    endtask

    task automatic doReset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        req_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        req_data  = {req_bytes[3], req_bytes[2], req_bytes[1], req_bytes[0]};
        rst = 1'b0;
        applyStimulus(4'hF, 1'b0, 1'b1, 1'b0);

        // Round-robin bursts of four; reads keep the tracked level at zero.
        for (int k = 0; k < 16; k++) begin
            vecs[k] = '{4'hF, 1'b1, 1'b0, 4'(1 << (k / 4)), 1'b1, req_bytes[k / 4], 3'd0, 2'(k / 4)};
        end
        // Requester 2 bursts two beats, others are locked out, then 0 wins from rr_ptr = 3.
        vecs[16] = '{4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h33, 3'd1, 2'd2};
        vecs[17] = '{4'b0111, 1'b0, 1'b1, 4'b0100, 1'b1, 8'h33, 3'd2, 2'd2};
        vecs[18] = '{4'b0001, 1'b0, 1'b1, 4'b0000, 1'b0, 8'h33, 3'd2, 2'd2};
        vecs[19] = '{4'b0001, 1'b0, 1'b1, 4'b0001, 1'b1, 8'h11, 3'd3, 2'd0};

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ready",    32'(req_ready),    32'h0);
        checkOutput("reset_wr_en",    32'(wr_en),        32'h0);
        checkOutput("reset_wr_data",  32'(wr_data),      32'h0);
        checkOutput("reset_level",    32'(level),        32'h0);
        checkOutput("reset_grant",    32'(grant_id),     32'h0);
        checkOutput("reset_overflow", 32'(overflow_err), 32'h0);

        @(negedge clk);
        rst = 1'b1;
        for (int v = 0; v < 20; v++) begin
            applyStimulus(vecs[v].valid, vecs[v].rd_en, vecs[v].empty, 1'b0);
            #1;
            checkOutput($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_wr_en", v),   32'(wr_en),        32'(vecs[v].exp_wr_en));
            checkOutput($sformatf("vec%0d_wr_data", v), 32'(wr_data),      32'(vecs[v].exp_data));
            checkOutput($sformatf("vec%0d_level", v),   32'(level),        32'(vecs[v].exp_level));
            checkOutput($sformatf("vec%0d_grant", v),   32'(grant_id),     32'(vecs[v].exp_grant));
            checkOutput($sformatf("vec%0d_overflow", v), 32'(overflow_err), 32'h0);
            @(negedge clk);
        end

        // Fill a depth-4 FIFO with no reads: exactly four beats get through.
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
        doReset();
        acc_count = 0;
        repeat (8) begin
            #1;
            if (req_ready[0]) acc_count++;
            @(negedge clk);
        end
        #1;
        checkOutput("fill_accepts",  32'(acc_count),    32'd4);
        checkOutput("fill_level",    32'(level),        32'd4);
        checkOutput("fill_ready",    32'(req_ready),    32'h0);
        checkOutput("fill_wr_en",    32'(wr_en),        32'h0);
        checkOutput("fill_overflow", 32'(overflow_err), 32'h0);

        // One read pulse frees one slot, which is refilled on the next cycle.
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("drain_ready_full", 32'(req_ready), 32'h0);
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("drain_level", 32'(level),     32'd3);
        checkOutput("drain_ready", 32'(req_ready), 32'b0001);
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("refill_level",   32'(level),     32'd4);
        checkOutput("refill_wr_en",   32'(wr_en),     32'h1);
        checkOutput("refill_wr_data", 32'(wr_data),   32'h11);
        checkOutput("refill_grant",   32'(grant_id),  32'h0);
        checkOutput("refill_ready",   32'(req_ready), 32'h0);

        // Write landing on a full FIFO with no read sets the sticky error.
        @(negedge clk);
        applyStimulus(4'b0001, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("overflow_set", 32'(overflow_err), 32'h1);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("overflow_sticky", 32'(overflow_err), 32'h1);
        checkOutput("overflow_level",  32'(level),        32'd4);

        // Reset in the middle of a burst, then release with a new requester set.
        applyStimulus(4'hF, 1'b0, 1'b1, 1'b0);
        doReset();
        #1;
        checkOutput("rst_clears_overflow", 32'(overflow_err), 32'h0);
        checkOutput("burst_first_ready",   32'(req_ready),    32'b0001);
        @(negedge clk);
        @(negedge clk);
        #1;
        checkOutput("burst_beat2_wr_en", 32'(wr_en), 32'h1);
        checkOutput("burst_beat2_level", 32'(level), 32'd2);
        rst = 1'b0;
        #1;
        checkOutput("midrst_ready",    32'(req_ready),    32'h0);
        checkOutput("midrst_wr_en",    32'(wr_en),        32'h0);
        checkOutput("midrst_wr_data",  32'(wr_data),      32'h0);
        checkOutput("midrst_level",    32'(level),        32'h0);
        checkOutput("midrst_grant",    32'(grant_id),     32'h0);
        checkOutput("midrst_overflow", 32'(overflow_err), 32'h0);
        applyStimulus(4'b1110, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'b0010);
        @(posedge clk);
        #1;
        checkOutput("post_rst_wr_en",   32'(wr_en),    32'h1);
        checkOutput("post_rst_wr_data", 32'(wr_data),  32'h22);
        checkOutput("post_rst_grant",   32'(grant_id), 32'h1);
        checkOutput("post_rst_level",   32'(level),    32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
